// File: rtl/ring_pkg.sv
// Shared types for the PtRing ring stop: flit layout, route and ring-out owner states.
package ring_pkg;

  localparam int DAT_W_DEF = 32;
  localparam int ID_W_DEF  = 4;

  typedef struct packed {
    logic                head;
    logic                tail;
    logic [ID_W_DEF-1:0] dst;
    logic [DAT_W_DEF-1:0] payload;
  } flit_t;

  typedef enum logic [1:0] {
    RIN_IDLE = 2'd0,
    RIN_FWD  = 2'd1,
    RIN_EJ   = 2'd2
  } route_e;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_THRU = 2'd1,
    OWN_INJ  = 2'd2
  } owner_e;

  function automatic int flit_w(input int dat_w, input int id_w);
    return dat_w + id_w + 2;
  endfunction

endpackage

// File: rtl/ring_out_arb.sv
// Ring-out link owner: arbitrates through traffic vs. injection with packet locking and
// an anti-starvation counter that lets injection win after STARVE_MAX waiting cycles.
module ring_out_arb
  import ring_pkg::*;
#(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic thru_req,
  input  logic thru_tail,
  input  logic inj_req,
  input  logic inj_tail,
  input  logic out_ful,
  output logic thru_go,
  output logic inj_go
);

  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  // Valid/ready: a source moves a flit only when its req is high and out_ful is low;
  // *_go is the combined transfer strobe and doubles as that source's FIFO pop.
  owner_e     owner, owner_nxt;
  logic [7:0] starve_cnt, starve_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner      <= OWN_IDLE;
      starve_cnt <= 8'd0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  always_comb begin
    thru_go    = 1'b0;
    inj_go     = 1'b0;
    owner_nxt  = owner;
    starve_nxt = starve_cnt;
    case (owner)
      OWN_IDLE: begin
        if (!out_ful) begin
          if (inj_req && (!thru_req || starve_cnt == SMAX)) inj_go = 1'b1;
          else if (thru_req)                                thru_go = 1'b1;
        end
        if (thru_go && !thru_tail) owner_nxt = OWN_THRU;
        if (inj_go && !inj_tail)   owner_nxt = OWN_INJ;
      end
      OWN_THRU: begin
        thru_go = thru_req && !out_ful;
        if (thru_go && thru_tail) owner_nxt = OWN_IDLE;
      end
      OWN_INJ: begin
        inj_go = inj_req && !out_ful;
        if (inj_go && inj_tail) owner_nxt = OWN_IDLE;
      end
      default: owner_nxt = OWN_IDLE;
    endcase
    // Only an inject head (owner not INJ) waits or is granted for starvation purposes.
    if (inj_go && owner == OWN_IDLE)
      starve_nxt = 8'd0;
    else if (inj_req && !inj_go && owner != OWN_INJ && starve_cnt != SMAX)
      starve_nxt = starve_cnt + 8'd1;
  end

endmodule

// File: rtl/ring_stop_arb.sv
// PtRing ring stop: decodes/locks the ring-in route, ejects local traffic and merges
// through traffic with injection onto ring-out, all with zero latency.
module ring_stop_arb
  import ring_pkg::*;
#(
  parameter  int DAT_W      = 32,
  parameter  int ID_W       = 4,
  parameter  int NODE_ID    = 0,
  parameter  int STARVE_MAX = 8,
  localparam int FLIT_W     = flit_w(DAT_W, ID_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iRingEmpty,
  input  logic [FLIT_W-1:0] iRingDat,
  output logic              oRingRdEn,
  input  logic              iInjEmpty,
  input  logic [FLIT_W-1:0] iInjDat,
  output logic              oInjRdEn,
  input  logic              iOutFul,
  output logic              oOutWrEn,
  output logic [FLIT_W-1:0] oOutWrDat,
  input  logic              iEjFul,
  output logic              oEjWrEn,
  output logic [FLIT_W-1:0] oEjWrDat,
  output logic              oLoopErr
);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(NODE_ID);

  logic            ring_tail, inj_head, inj_tail;
  logic [ID_W-1:0] ring_dst, inj_dst;
  route_e          route, route_sel;
  logic            ej_pop, thru_req, inj_req, thru_go, inj_go;

  assign ring_tail = iRingDat[FLIT_W-2];
  assign ring_dst  = iRingDat[DAT_W +: ID_W];
  assign inj_head  = iInjDat[FLIT_W-1];
  assign inj_tail  = iInjDat[FLIT_W-2];
  assign inj_dst   = iInjDat[DAT_W +: ID_W];

  // An idle route is decided by the current head; a locked route holds until the tail moves.
  always_comb begin
    route_sel = route;
    if (route == RIN_IDLE) route_sel = (ring_dst == MY_ID) ? RIN_EJ : RIN_FWD;
  end

  // Every request is qualified by rst so nothing moves during the reset cycle.
  assign ej_pop   = rst && !iRingEmpty && (route_sel == RIN_EJ) && !iEjFul;
  assign thru_req = rst && !iRingEmpty && (route_sel == RIN_FWD);
  assign inj_req  = rst && !iInjEmpty;

  ring_out_arb #(
    .STARVE_MAX(STARVE_MAX)
  ) u_out_arb (
    .clk      (clk),
    .rst      (rst),
    .thru_req (thru_req),
    .thru_tail(ring_tail),
    .inj_req  (inj_req),
    .inj_tail (inj_tail),
    .out_ful  (iOutFul),
    .thru_go  (thru_go),
    .inj_go   (inj_go)
  );

  always_ff @(posedge clk) begin
    if (!rst)           route <= RIN_IDLE;
    else if (oRingRdEn) route <= ring_tail ? RIN_IDLE : route_sel;
  end

  assign oRingRdEn = ej_pop || thru_go;
  assign oInjRdEn  = inj_go;
  assign oEjWrEn   = ej_pop;
  assign oEjWrDat  = ej_pop ? iRingDat : '0;
  assign oOutWrEn  = thru_go || inj_go;
  assign oOutWrDat = thru_go ? iRingDat : (inj_go ? iInjDat : '0);
  assign oLoopErr  = inj_go && inj_head && (inj_dst == MY_ID);

endmodule

// File: tb/tb_ring_stop_arb.sv
// Directed bench for ring_stop_arb: FIFO heads modelled by queues, per-cycle hand-derived expectations.
module tb_ring_stop_arb;
  import ring_pkg::*;

  localparam int FW = 38;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          iRingEmpty, iInjEmpty, iOutFul, iEjFul;
  logic [FW-1:0] iRingDat, iInjDat;
  logic          oRingRdEn, oInjRdEn, oOutWrEn, oEjWrEn, oLoopErr;
  logic [FW-1:0] oOutWrDat, oEjWrDat;
  logic [4:0]    ctl;
  logic [FW-1:0] ring_q[$];
  logic [FW-1:0] inj_q[$];
  int            checks = 0;
  int            failures = 0;

  always #5 clk = ~clk;

  ring_stop_arb #(.DAT_W(32), .ID_W(4), .NODE_ID(0), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .iRingEmpty(iRingEmpty), .iRingDat(iRingDat), .oRingRdEn(oRingRdEn),
    .iInjEmpty(iInjEmpty), .iInjDat(iInjDat), .oInjRdEn(oInjRdEn),
    .iOutFul(iOutFul), .oOutWrEn(oOutWrEn), .oOutWrDat(oOutWrDat),
    .iEjFul(iEjFul), .oEjWrEn(oEjWrEn), .oEjWrDat(oEjWrDat),
    .oLoopErr(oLoopErr)
  );

  // {ring pop, inject pop, out write, eject write, loop error}
  assign ctl = {oRingRdEn, oInjRdEn, oOutWrEn, oEjWrEn, oLoopErr};

  function automatic logic [FW-1:0] mk(input logic h, input logic t, input logic [3:0] d,
                                       input logic [31:0] p);
    flit_t f;
    f.head = h; f.tail = t; f.dst = d; f.payload = p;
    return f;
  endfunction

  task automatic drive();
    iRingEmpty = (ring_q.size() == 0);
    iRingDat   = iRingEmpty ? '0 : ring_q[0];
    iInjEmpty  = (inj_q.size() == 0);
    iInjDat    = iInjEmpty ? '0 : inj_q[0];
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic tick();
    logic pr, pi;
    pr = oRingRdEn;
    pi = oInjRdEn;
    @(posedge clk);
    #1;
    if (pr && ring_q.size() > 0) ring_q.delete(0);
    if (pi && inj_q.size() > 0)  inj_q.delete(0);
    drive();
  endtask

  task automatic test_reset();
    ring_q.push_back(mk(1, 1, 0, 32'h11));
    inj_q.push_back(mk(1, 1, 0, 32'h22));
    drive();
    @(posedge clk);
    #1;
    settle();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 5'b00000);
    end
    checks++;
    if (oOutWrDat !== '0 || oEjWrDat !== '0) begin
      failures++; $display("FAIL reset_data got out=%0h ej=%0h exp=0", oOutWrDat, oEjWrDat);
    end
    checks++;
    if (dut.u_out_arb.starve_cnt !== 8'd0 || dut.u_out_arb.owner !== OWN_IDLE) begin
      failures++;
      $display("FAIL reset_state got starve=%0d owner=%0d exp=0/0",
               dut.u_out_arb.starve_cnt, dut.u_out_arb.owner);
    end
    ring_q.delete();
    inj_q.delete();
    drive();
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_eject();
    logic [FW-1:0] f;
    f = mk(1, 1, 0, 32'hA5A5_0001);
    ring_q.push_back(f);
    drive();
    settle();
    checks++;
    if (ctl !== 5'b10010) begin
      failures++; $display("FAIL eject_ctl got=%b exp=%b", ctl, 5'b10010);
    end
    checks++;
    if (oEjWrDat !== f || oOutWrDat !== '0) begin
      failures++; $display("FAIL eject_data got ej=%0h out=%0h exp ej=%0h out=0", oEjWrDat, oOutWrDat, f);
    end
    tick();
    settle();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL eject_idle got=%b exp=%b", ctl, 5'b00000);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] f[3];
    logic [FW-1:0] g;
    f[0] = mk(1, 0, 2, 32'hB0); f[1] = mk(0, 0, 2, 32'hB1); f[2] = mk(0, 1, 2, 32'hB2);
    g = mk(1, 1, 3, 32'hC0);
    for (int k = 0; k < 3; k++) ring_q.push_back(f[k]);
    inj_q.push_back(g);
    drive();
    for (int k = 0; k < 3; k++) begin
      settle();
      checks++;
      if (ctl !== 5'b10100 || oOutWrDat !== f[k]) begin
        failures++; $display("FAIL b2b_ring%0d got ctl=%b dat=%0h exp ctl=10100 dat=%0h", k, ctl, oOutWrDat, f[k]);
      end
      checks++;
      if (dut.u_out_arb.starve_cnt !== 8'(k)) begin
        failures++; $display("FAIL b2b_starve%0d got=%0d exp=%0d", k, dut.u_out_arb.starve_cnt, k);
      end
      tick();
    end
    settle();
    checks++;
    if (ctl !== 5'b01100 || oOutWrDat !== g || dut.u_out_arb.starve_cnt !== 8'd3) begin
      failures++;
      $display("FAIL b2b_inject got ctl=%b dat=%0h starve=%0d exp ctl=01100 dat=%0h starve=3",
               ctl, oOutWrDat, dut.u_out_arb.starve_cnt, g);
    end
    tick();
    settle();
    checks++;
    if (ctl !== 5'b00000 || dut.u_out_arb.starve_cnt !== 8'd0) begin
      failures++; $display("FAIL b2b_clear got ctl=%b starve=%0d exp 00000/0", ctl, dut.u_out_arb.starve_cnt);
    end
    tick();
  endtask

  task automatic test_starve();
    logic [FW-1:0] r[10];
    logic [FW-1:0] g;
    logic [FW-1:0] exp_dat;
    logic [4:0]    exp_ctl;
    int            idx;
    g = mk(1, 1, 5, 32'hD00D);
    for (int k = 0; k < 10; k++) begin
      r[k] = mk(1, 1, 1, 32'(100 + k));
      ring_q.push_back(r[k]);
    end
    inj_q.push_back(g);
    drive();
    for (int c = 1; c <= 11; c++) begin
      settle();
      if (c == 9) begin
        exp_ctl = 5'b01100; exp_dat = g;
      end else begin
        idx = (c < 9) ? c - 1 : c - 2;
        exp_ctl = 5'b10100; exp_dat = r[idx];
      end
      checks++;
      if (ctl !== exp_ctl || oOutWrDat !== exp_dat) begin
        failures++;
        $display("FAIL starve_c%0d got ctl=%b dat=%0h exp ctl=%b dat=%0h", c, ctl, oOutWrDat, exp_ctl, exp_dat);
      end
      checks++;
      if (dut.u_out_arb.starve_cnt !== ((c <= 9) ? 8'(c - 1) : 8'd0)) begin
        failures++; $display("FAIL starve_cnt_c%0d got=%0d", c, dut.u_out_arb.starve_cnt);
      end
      tick();
    end
  endtask

  task automatic test_out_full();
    logic [FW-1:0] j[4];
    logic [FW-1:0] r;
    j[0] = mk(1, 0, 1, 32'hE0); j[1] = mk(0, 0, 1, 32'hE1);
    j[2] = mk(0, 0, 1, 32'hE2); j[3] = mk(0, 1, 1, 32'hE3);
    r = mk(1, 1, 2, 32'hF0);
    for (int k = 0; k < 4; k++) inj_q.push_back(j[k]);
    drive();
    for (int c = 1; c <= 9; c++) begin
      settle();
      case (c)
        1, 2: begin
          checks++;
          if (ctl !== 5'b01100 || oOutWrDat !== j[c-1]) begin
            failures++; $display("FAIL full_inj_c%0d got ctl=%b dat=%0h exp ctl=01100 dat=%0h", c, ctl, oOutWrDat, j[c-1]);
          end
        end
        3, 4, 5, 6: begin
          checks++;
          if (ctl !== 5'b00000 || oOutWrDat !== '0 || dut.u_out_arb.owner !== OWN_INJ) begin
            failures++;
            $display("FAIL full_hold_c%0d got ctl=%b dat=%0h owner=%0d exp ctl=00000 dat=0 owner=2",
                     c, ctl, oOutWrDat, dut.u_out_arb.owner);
          end
        end
        7, 8: begin
          checks++;
          if (ctl !== 5'b01100 || oOutWrDat !== j[c-5]) begin
            failures++; $display("FAIL full_resume_c%0d got ctl=%b dat=%0h exp ctl=01100 dat=%0h", c, ctl, oOutWrDat, j[c-5]);
          end
        end
        default: begin
          checks++;
          if (ctl !== 5'b10100 || oOutWrDat !== r) begin
            failures++; $display("FAIL full_ring got ctl=%b dat=%0h exp ctl=10100 dat=%0h", ctl, oOutWrDat, r);
          end
        end
      endcase
      tick();
      if (c == 1) begin
        ring_q.push_back(r);
        drive();
      end
      if (c == 2) iOutFul = 1'b1;
      if (c == 6) iOutFul = 1'b0;
    end
  endtask

  task automatic test_ej_stall();
    logic [FW-1:0] e[2];
    logic [FW-1:0] k[2];
    e[0] = mk(1, 0, 0, 32'h1E0); e[1] = mk(0, 1, 0, 32'h1E1);
    k[0] = mk(1, 0, 3, 32'h2A0); k[1] = mk(0, 1, 3, 32'h2A1);
    ring_q.push_back(e[0]); ring_q.push_back(e[1]);
    inj_q.push_back(k[0]); inj_q.push_back(k[1]);
    iEjFul = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (ctl !== 5'b01100 || oOutWrDat !== k[c] || oEjWrDat !== '0) begin
        failures++;
        $display("FAIL ejstall_inj%0d got ctl=%b out=%0h ej=%0h exp ctl=01100 out=%0h ej=0", c, ctl, oOutWrDat, oEjWrDat, k[c]);
      end
      tick();
    end
    iEjFul = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      checks++;
      if (ctl !== 5'b10010 || oEjWrDat !== e[c] || oOutWrDat !== '0) begin
        failures++;
        $display("FAIL ejstall_ej%0d got ctl=%b ej=%0h out=%0h exp ctl=10010 ej=%0h out=0", c, ctl, oEjWrDat, oOutWrDat, e[c]);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] m0;
    logic [FW-1:0] rh;
    logic [FW-1:0] ih;
    m0 = mk(1, 0, 2, 32'h300);
    ring_q.push_back(m0); ring_q.push_back(mk(0, 0, 2, 32'h301)); ring_q.push_back(mk(0, 1, 2, 32'h302));
    drive();
    settle();
    checks++;
    if (ctl !== 5'b10100 || oOutWrDat !== m0) begin
      failures++; $display("FAIL rstmid_first got ctl=%b dat=%0h exp ctl=10100 dat=%0h", ctl, oOutWrDat, m0);
    end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (ctl !== 5'b00000 || oOutWrDat !== '0 || oEjWrDat !== '0) begin
      failures++; $display("FAIL rstmid_gate got ctl=%b out=%0h ej=%0h exp all 0", ctl, oOutWrDat, oEjWrDat);
    end
    tick();
    rst = 1'b1;
    ring_q.delete();
    rh = mk(1, 1, 0, 32'h400);
    ih = mk(1, 1, 0, 32'h500);
    ring_q.push_back(rh);
    inj_q.push_back(ih);
    drive();
    settle();
    checks++;
    if (ctl !== 5'b11111 || oOutWrDat !== ih || oEjWrDat !== rh) begin
      failures++;
      $display("FAIL rstmid_rearb got ctl=%b out=%0h ej=%0h exp ctl=11111 out=%0h ej=%0h", ctl, oOutWrDat, oEjWrDat, ih, rh);
    end
    tick();
    settle();
    checks++;
    if (ctl !== 5'b00000) begin
      failures++; $display("FAIL rstmid_loop_pulse got ctl=%b exp=00000", ctl);
    end
    tick();
  endtask

  initial begin
    iOutFul = 1'b0;
    iEjFul  = 1'b0;
    drive();
    test_reset();
    test_eject();
    test_back_to_back();
    test_starve();
    test_out_full();
    test_ej_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
